// File: rtl/uart_echo_fifo_if.sv
// Handshake bundle between the echo controller and the UART core.
// The master side is the echo controller; the slave side is the UART core.
interface uart_echo_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_complete_flag;
  logic              rx_complete_del_flag;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_complete_flag;
  logic              tx_complete_del_flag;
  logic [9:0]        baudselect;

  modport master (
    input  rx_data, rx_complete_flag, tx_busy, tx_complete_flag,
    output rx_complete_del_flag, tx_data, tx_start, tx_complete_del_flag, baudselect
  );

  modport slave (
    output rx_data, rx_complete_flag, tx_busy, tx_complete_flag,
    input  rx_complete_del_flag, tx_data, tx_start, tx_complete_del_flag, baudselect
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: queues received bytes in a circular FIFO and replays them,
// with optional upper-case folding, CR->CR LF expansion and echo suppression.
module uart_echo_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned BAUD_DIV = 325
) (
  input  logic                         clk,
  input  logic                         reset_n,
  uart_echo_fifo_if.master             core,
  input  logic                         echo_en,
  input  logic                         upper_en,
  input  logic                         crlf_en,
  input  logic                         ovf_clr,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              rx_flag_q, rx_del_q, tx_del_q;
  logic [1:0]        state_q, state_d;
  logic              lf_pending_q, lf_pending_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic              push_ev, push_ok, pop, full;
  logic [DATA_W-1:0] head, head_f;

  always_comb begin
    push_ev = core.rx_complete_flag && !rx_flag_q && echo_en;
    full    = (level_q == LVL_W'(DEPTH));
    pop     = (state_q == S_IDLE) && !lf_pending_q && (level_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push_ev && (!full || pop);
    head    = mem_q[rd_ptr_q];
    head_f  = head;
    if (upper_en && head >= DATA_W'(32'h61) && head <= DATA_W'(32'h7A))
      head_f = head - DATA_W'(32'h20);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    ovf_d        = ovf_q;
    state_d      = state_q;
    lf_pending_d = lf_pending_q;
    tx_start_d   = tx_start_q;
    tx_data_d    = tx_data_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push_ok) level_d = level_q - LVL_W'(1);

    if (ovf_clr)                 ovf_d = 1'b0;
    if (push_ev && full && !pop) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (lf_pending_q) begin
          tx_data_d    = DATA_W'(32'h0A);
          lf_pending_d = 1'b0;
          tx_start_d   = 1'b1;
          state_d      = S_WAIT_BUSY;
        end else if (pop) begin
          tx_data_d  = head_f;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_BUSY;
          if (crlf_en && head == DATA_W'(32'h0D)) lf_pending_d = 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (core.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!core.tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      rx_flag_q    <= 1'b0;
      rx_del_q     <= 1'b0;
      tx_del_q     <= 1'b0;
      state_q      <= S_IDLE;
      lf_pending_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
      rx_flag_q    <= core.rx_complete_flag;
      rx_del_q     <= core.rx_complete_flag;
      tx_del_q     <= core.tx_complete_flag;
      state_q      <= state_d;
      lf_pending_q <= lf_pending_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Storage needs no reset: the level counter defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= core.rx_data;
  end

  assign core.tx_start             = tx_start_q;
  assign core.tx_data              = tx_data_q;
  assign core.rx_complete_del_flag = rx_del_q;
  assign core.tx_complete_del_flag = tx_del_q;
  assign core.baudselect           = 10'(BAUD_DIV);
  assign fifo_level                = level_q;
  assign overflow                  = ovf_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: a UART core model captures each launched
// byte and compares it with the expected byte queued when the stimulus was sent.
module tb_uart_echo_fifo;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       echo_en, upper_en, crlf_en, ovf_clr;
  logic [4:0] fifo_level;
  logic       overflow;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_launch = 0;
  bit         hold_busy = 1'b0;
  logic [7:0] sb[$];

  uart_echo_fifo_if #(.DATA_W(8)) bus ();

  uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .BAUD_DIV(325)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core       (bus.master),
    .echo_en    (echo_en),
    .upper_en   (upper_en),
    .crlf_en    (crlf_en),
    .ovf_clr    (ovf_clr),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // Core model: capture on tx_start, raise busy 3 cycles later, finish with a done pulse.
  initial begin
    bus.tx_busy          = 1'b0;
    bus.tx_complete_flag = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.tx_start && !bus.tx_busy) begin
        n_launch++;
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) check("tx_data", bus.tx_data, sb.pop_front());
        repeat (3) @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (4) @(posedge clk);
        while (hold_busy) @(posedge clk);
        #1;
        bus.tx_busy          = 1'b0;
        bus.tx_complete_flag = 1'b1;
        @(posedge clk); #1;
        bus.tx_complete_flag = 1'b0;
        check("tx_cdel", bus.tx_complete_del_flag, 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit accept);
    int i;
    if (echo_en && accept) begin
      sb.push_back(upper_en ? fold(b) : b);
      if (crlf_en && b == 8'h0D) sb.push_back(8'h0A);
    end
    bus.rx_data          = b;
    bus.rx_complete_flag = 1'b1;
    i = 0;
    while (!bus.rx_complete_del_flag && i < 10) begin
      @(negedge clk);
      i++;
    end
    check("rx_del_rise", bus.rx_complete_del_flag, 1);
    @(posedge clk); #1;
    bus.rx_complete_flag = 1'b0;
    @(posedge clk); #1;
    check("rx_del_fall", bus.rx_complete_del_flag, 0);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (!(sb.size() == 0 && fifo_level == 0 && !bus.tx_start && !bus.tx_busy) && i < 3000) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_sb", sb.size(), 0);
    check("drain_level", fifo_level, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    int launches;
    reset_n              = 1'b0;
    echo_en              = 1'b1;
    upper_en             = 1'b0;
    crlf_en              = 1'b0;
    ovf_clr              = 1'b0;
    bus.rx_data          = 8'h00;
    bus.rx_complete_flag = 1'b0;
    #12;
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_rx_del", bus.rx_complete_del_flag, 0);
    check("rst_tx_del", bus.tx_complete_del_flag, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("baudselect", bus.baudselect, 325);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte latency: flag sampled at edge N.
    sb.push_back(8'h41);
    bus.rx_data          = 8'h41;
    bus.rx_complete_flag = 1'b1;
    @(posedge clk); #1;
    check("lat_level_n", fifo_level, 1);
    check("lat_start_n", bus.tx_start, 0);
    check("lat_del_n", bus.rx_complete_del_flag, 1);
    bus.rx_complete_flag = 1'b0;
    @(posedge clk); #1;
    check("lat_start_n1", bus.tx_start, 1);
    check("lat_data_n1", bus.tx_data, 8'h41);
    check("lat_level_n1", fifo_level, 0);
    check("lat_del_fall", bus.rx_complete_del_flag, 0);
    i = 0;
    while (!bus.tx_busy && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("busy_seen", bus.tx_busy, 1);
    @(posedge clk); #1;
    check("start_drop", bus.tx_start, 0);
    drain();

    // Zero byte is echoed.
    send_byte(8'h00, 1'b1);
    drain();

    // Burst into a stalled transmitter.
    hold_busy = 1'b1;
    for (int b = 1; b <= 20; b++) send_byte(8'(b), b <= 17);
    check("burst_level", fifo_level, 16);
    check("burst_ovf", overflow, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    hold_busy = 1'b0;
    drain();

    // Folding and CR expansion, with range boundaries.
    upper_en = 1'b1;
    crlf_en  = 1'b1;
    send_byte(8'h61, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h7A, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h7B, 1'b1);
    drain();
    upper_en = 1'b0;
    crlf_en  = 1'b0;

    // Echo suppressed: flag still acknowledged, nothing queued.
    echo_en  = 1'b0;
    launches = n_launch;
    for (int b = 0; b < 3; b++) begin
      send_byte(8'h30 + 8'(b), 1'b1);
      check("noecho_level", fifo_level, 0);
    end
    repeat (10) @(posedge clk);
    #1;
    check("noecho_launch", n_launch, launches);
    echo_en = 1'b1;

    // Reset while waiting for the transmitter, with bytes queued.
    hold_busy = 1'b1;
    send_byte(8'h55, 1'b1);
    for (int b = 0; b < 5; b++) send_byte(8'h60 + 8'(b), 1'b0);
    check("pre_rst_level", fifo_level, 5);
    #3 reset_n = 1'b0;
    #1;
    check("arst_start", bus.tx_start, 0);
    check("arst_level", fifo_level, 0);
    check("arst_ovf", overflow, 0);
    hold_busy = 1'b0;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    launches = n_launch;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_launch", n_launch, launches);
    send_byte(8'h42, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
